// File: rtl/sdram_dma_pkg.sv
// Shared register map, control/status bit positions and FSM state codes for the
// sdram_dma block copy/fill engine.
package sdram_dma_pkg;

   localparam logic [2:0] REG_SRC  = 3'd0;
   localparam logic [2:0] REG_DST  = 3'd1;
   localparam logic [2:0] REG_LEN  = 3'd2;
   localparam logic [2:0] REG_CTRL = 3'd3;
   localparam logic [2:0] REG_FILL = 3'd4;

   localparam int CTRL_START  = 0;
   localparam int CTRL_FILL   = 1;
   localparam int CTRL_IRQ_EN = 2;
   localparam int CTRL_ABORT  = 3;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_ABORTED = 2;
   localparam int STAT_FILL    = 4;
   localparam int STAT_IRQ_EN  = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_GAP,
      ST_WR_REQ,
      ST_WR_GAP,
      ST_FIN
   } dma_state_t;

endpackage

// File: rtl/sdram_dma_buf.sv
// Chunk staging buffer for sdram_dma: one synchronous write port, one
// asynchronous read port, data is not reset.
module dma_buf #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [15:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [15:0]   rdata
);

   logic [15:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sdram_dma.sv
// Register-programmed block copy/fill engine, sole master on memhub bus B.
// Moves data in chunks of up to BUF_DEPTH halfwords through dma_buf.
module sdram_dma
   import sdram_dma_pkg::*;
#(
   parameter int BUF_DEPTH = 8,
   parameter int LEN_BITS  = 24,
   parameter int ADDR_BITS = 26
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cfg_wr,
   input  logic [2:0]           cfg_addr,
   input  logic [31:0]          cfg_wdata,
   output logic [31:0]          cfg_rdata,
   output logic                 irq,
   output logic                 m_cs,
   output logic                 m_rd,
   output logic                 m_wr,
   output logic [1:0]           m_mask,
   input  logic                 m_nwait,
   output logic [ADDR_BITS-1:0] m_addr,
   output logic [15:0]          m_wdata,
   input  logic [15:0]          m_rdata
);

   localparam int AW    = $clog2(BUF_DEPTH);
   localparam int IDX_W = AW + 1;

   dma_state_t state, state_d;

   logic [ADDR_BITS-1:0] src, src_d, dst, dst_d;
   logic [LEN_BITS-1:0]  len_cnt, len_d;
   logic [15:0]          fill_pat, fill_d;
   logic [IDX_W-1:0]     idx, idx_d, chunk, chunk_d;
   logic                 done, done_d, aborted, aborted_d;
   logic                 abort_pend, abort_pend_d;
   logic                 fill_mode, fill_mode_d, irq_en, irq_en_d;
   logic                 busy, ctrl_wr, start_req, abort_now, buf_we;
   logic [15:0]          buf_rdata;
   logic [IDX_W-1:0]     len_chunk;
   logic                 unused_cfg;

   dma_buf #(.DEPTH(BUF_DEPTH), .AW(AW)) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (idx[AW-1:0]),
      .wdata (m_rdata),
      .raddr (idx_d[AW-1:0]),
      .rdata (buf_rdata)
   );

   assign busy       = (state != ST_IDLE);
   assign ctrl_wr    = cfg_wr && (cfg_addr == REG_CTRL);
   assign start_req  = ctrl_wr && cfg_wdata[CTRL_START] && !cfg_wdata[CTRL_ABORT];
   assign abort_now  = abort_pend || (ctrl_wr && cfg_wdata[CTRL_ABORT]);
   assign len_chunk  = (len_cnt >= LEN_BITS'(BUF_DEPTH)) ? IDX_W'(BUF_DEPTH) : IDX_W'(len_cnt);
   assign irq        = done && irq_en;
   assign m_mask     = 2'b00;
   assign unused_cfg = ^cfg_wdata;

   // Register read mux; the progress counters are visible live while busy.
   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         REG_SRC:  cfg_rdata = 32'(src);
         REG_DST:  cfg_rdata = 32'(dst);
         REG_LEN:  cfg_rdata = 32'(len_cnt);
         REG_CTRL: begin
            cfg_rdata[STAT_BUSY]    = busy;
            cfg_rdata[STAT_DONE]    = done;
            cfg_rdata[STAT_ABORTED] = aborted;
            cfg_rdata[STAT_FILL]    = fill_mode;
            cfg_rdata[STAT_IRQ_EN]  = irq_en;
         end
         REG_FILL: cfg_rdata = {16'h0000, fill_pat};
         default:  cfg_rdata = '0;
      endcase
   end

   // Next-state and datapath: config writes first, then the FSM may override counters.
   always_comb begin
      state_d      = state;
      src_d        = src;
      dst_d        = dst;
      len_d        = len_cnt;
      fill_d       = fill_pat;
      idx_d        = idx;
      chunk_d      = chunk;
      done_d       = done;
      aborted_d    = aborted;
      abort_pend_d = abort_pend;
      fill_mode_d  = fill_mode;
      irq_en_d     = irq_en;
      buf_we       = 1'b0;

      if (cfg_wr && !busy) begin
         case (cfg_addr)
            REG_SRC:  src_d  = {cfg_wdata[ADDR_BITS-1:1], 1'b0};
            REG_DST:  dst_d  = {cfg_wdata[ADDR_BITS-1:1], 1'b0};
            REG_LEN:  len_d  = cfg_wdata[LEN_BITS-1:0];
            REG_FILL: fill_d = cfg_wdata[15:0];
            default:  ;
         endcase
      end
      if (ctrl_wr) begin
         irq_en_d = cfg_wdata[CTRL_IRQ_EN];
         if (!busy)
            fill_mode_d = cfg_wdata[CTRL_FILL];
         else if (cfg_wdata[CTRL_ABORT])
            abort_pend_d = 1'b1;
      end

      case (state)
         ST_IDLE: begin
            abort_pend_d = 1'b0;
            if (start_req) begin
               done_d    = 1'b0;
               aborted_d = 1'b0;
               if (len_cnt == '0) begin
                  state_d = ST_FIN;
               end else begin
                  chunk_d = len_chunk;
                  idx_d   = '0;
                  state_d = fill_mode_d ? ST_WR_REQ : ST_RD_REQ;
               end
            end
         end
         ST_RD_REQ: begin
            if (m_nwait) begin
               buf_we  = 1'b1;
               src_d   = src + ADDR_BITS'(2);
               idx_d   = idx + IDX_W'(1);
               state_d = ST_RD_GAP;
            end
         end
         ST_RD_GAP: begin
            if (abort_now) begin
               aborted_d    = 1'b1;
               abort_pend_d = 1'b0;
               state_d      = ST_IDLE;
            end else if (idx == chunk) begin
               idx_d   = '0;
               state_d = ST_WR_REQ;
            end else begin
               state_d = ST_RD_REQ;
            end
         end
         ST_WR_REQ: begin
            if (m_nwait) begin
               dst_d   = dst + ADDR_BITS'(2);
               idx_d   = idx + IDX_W'(1);
               len_d   = len_cnt - LEN_BITS'(1);
               state_d = ST_WR_GAP;
            end
         end
         ST_WR_GAP: begin
            if (len_cnt == '0) begin
               state_d = ST_FIN;
            end else if (abort_now) begin
               aborted_d    = 1'b1;
               abort_pend_d = 1'b0;
               state_d      = ST_IDLE;
            end else if (idx == chunk) begin
               chunk_d = len_chunk;
               idx_d   = '0;
               state_d = fill_mode ? ST_WR_REQ : ST_RD_REQ;
            end else begin
               state_d = ST_WR_REQ;
            end
         end
         ST_FIN: begin
            done_d       = 1'b1;
            abort_pend_d = 1'b0;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus outputs are registered from the next state so they hold steady for a whole access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         src        <= '0;
         dst        <= '0;
         len_cnt    <= '0;
         fill_pat   <= '0;
         idx        <= '0;
         chunk      <= '0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         abort_pend <= 1'b0;
         fill_mode  <= 1'b0;
         irq_en     <= 1'b0;
         m_cs       <= 1'b0;
         m_rd       <= 1'b0;
         m_wr       <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
      end else begin
         state      <= state_d;
         src        <= src_d;
         dst        <= dst_d;
         len_cnt    <= len_d;
         fill_pat   <= fill_d;
         idx        <= idx_d;
         chunk      <= chunk_d;
         done       <= done_d;
         aborted    <= aborted_d;
         abort_pend <= abort_pend_d;
         fill_mode  <= fill_mode_d;
         irq_en     <= irq_en_d;
         m_cs       <= (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
         m_rd       <= (state_d == ST_RD_REQ);
         m_wr       <= (state_d == ST_WR_REQ);
         m_addr     <= (state_d == ST_RD_REQ) ? src_d :
                       (state_d == ST_WR_REQ) ? dst_d : '0;
         m_wdata    <= (state_d == ST_WR_REQ) ? (fill_mode_d ? fill_d : buf_rdata) : '0;
      end
   end

endmodule

// File: tb/tb_sdram_dma.sv
// Directed bench for sdram_dma: copy, fill, wait states, address wrap, abort,
// zero-length start and reset mid-transfer against a simple bus-B memory model.
module tb_sdram_dma;
   import sdram_dma_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_wr = 1'b0;
   logic [2:0]  cfg_addr = 3'd0;
   logic [31:0] cfg_wdata = 32'd0;
   logic [31:0] cfg_rdata;
   logic        irq, m_cs, m_rd, m_wr;
   logic [1:0]  m_mask;
   logic        m_nwait = 1'b1;
   logic [25:0] m_addr;
   logic [15:0] m_wdata, m_rdata;

   int n_checks = 0;
   int n_errors = 0;
   int wait_n = 0;
   int wait_cnt = 0;
   int stab_err = 0;
   logic        cs_prev = 1'b0;
   logic        cs_seen = 1'b0;
   logic [25:0] hold_addr;
   logic [15:0] hold_wdata;
   logic        hold_rd, hold_wr;
   logic [25:0] wr_addr[$];
   logic [15:0] wr_data[$];
   logic        op_log[$];

   sdram_dma dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_wr    (cfg_wr),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_rdata (cfg_rdata),
      .irq       (irq),
      .m_cs      (m_cs),
      .m_rd      (m_rd),
      .m_wr      (m_wr),
      .m_mask    (m_mask),
      .m_nwait   (m_nwait),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_rdata   (m_rdata)
   );

   always #5 clk = ~clk;

   // Source memory content is a fixed function of the address.
   assign m_rdata = m_addr[15:0] ^ 16'h5A3C;

   // Wait-state generator plus hold-stability monitor for pending accesses.
   always @(negedge clk) begin
      if (m_cs) begin
         if (cs_prev && (m_addr !== hold_addr || m_wdata !== hold_wdata ||
                         m_rd !== hold_rd || m_wr !== hold_wr))
            stab_err++;
         hold_addr  = m_addr;
         hold_wdata = m_wdata;
         hold_rd    = m_rd;
         hold_wr    = m_wr;
         if (wait_cnt < wait_n) begin
            m_nwait = 1'b0;
            wait_cnt++;
         end else begin
            m_nwait = 1'b1;
         end
      end else begin
         wait_cnt = 0;
         m_nwait  = 1'b1;
      end
      cs_prev = m_cs;
   end

   always @(posedge clk) begin
      if (m_cs)
         cs_seen = 1'b1;
      if (m_cs && m_nwait) begin
         if (m_wr) begin
            wr_addr.push_back(m_addr);
            wr_data.push_back(m_wdata);
            op_log.push_back(1'b1);
         end else begin
            op_log.push_back(1'b0);
         end
      end
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      cfg_wr    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      @(negedge clk);
      cfg_wr    = 1'b0;
   endtask

   task automatic read_reg(input logic [2:0] a, output logic [31:0] v);
      cfg_addr = a;
      #1;
      v = cfg_rdata;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      logic [31:0] st;
      read_reg(REG_CTRL, st);
      while (st[STAT_BUSY] && n < budget) begin
         @(negedge clk);
         read_reg(REG_CTRL, st);
         n++;
      end
      check_output("idle_timeout", 32'(n < budget), 32'd1);
   endtask

   task automatic clear_logs();
      wr_addr.delete();
      wr_data.delete();
      op_log.delete();
      stab_err = 0;
      cs_seen  = 1'b0;
   endtask

   task automatic check_copy(input string tag, input logic [25:0] src0, input logic [25:0] dst0, input int n);
      logic [25:0] sa;
      check_output({tag, "_wr_count"}, 32'(wr_addr.size()), 32'(n));
      for (int i = 0; i < n && i < wr_addr.size(); i++) begin
         sa = src0 + 26'(2 * i);
         check_output($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(dst0 + 26'(2 * i)));
         check_output($sformatf("%s_data%0d", tag, i), 32'(wr_data[i]), 32'(sa[15:0] ^ 16'h5A3C));
      end
   endtask

   logic [31:0] v;
   logic        exp_ops[$];
   int          diffs;
   int          n_wait;
   int          chunks[3] = '{8, 8, 4};

   initial begin
      $display("[TB] sdram_dma directed test start");
      #3 reset = 1'b0;
      #4;
      check_output("rst_cs", 32'(m_cs), 32'd0);
      check_output("rst_rd_wr", 32'({m_rd, m_wr}), 32'd0);
      check_output("rst_irq", 32'(irq), 32'd0);
      check_output("rst_addr", 32'(m_addr), 32'd0);
      check_output("rst_wdata", 32'(m_wdata), 32'd0);
      check_output("rst_mask", 32'(m_mask), 32'd0);
      read_reg(REG_CTRL, v);
      check_output("rst_status", v, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Chunked copy of 20 halfwords with zero wait states.
      clear_logs();
      apply_stimulus(REG_SRC, 32'h1000);
      apply_stimulus(REG_DST, 32'h2000);
      apply_stimulus(REG_LEN, 32'd20);
      apply_stimulus(REG_CTRL, 32'h5);
      wait_idle(2000);
      check_copy("copy", 26'h1000, 26'h2000, 20);
      exp_ops.delete();
      foreach (chunks[c]) begin
         for (int k = 0; k < chunks[c]; k++) exp_ops.push_back(1'b0);
         for (int k = 0; k < chunks[c]; k++) exp_ops.push_back(1'b1);
      end
      check_output("copy_op_count", 32'(op_log.size()), 32'd40);
      diffs = 0;
      for (int i = 0; i < 40 && i < op_log.size(); i++)
         if (op_log[i] !== exp_ops[i]) diffs++;
      check_output("copy_op_order", 32'(diffs), 32'd0);
      read_reg(REG_SRC, v);
      check_output("copy_src_end", v, 32'h1028);
      read_reg(REG_DST, v);
      check_output("copy_dst_end", v, 32'h2028);
      read_reg(REG_LEN, v);
      check_output("copy_len_end", v, 32'd0);
      read_reg(REG_CTRL, v);
      check_output("copy_status", v, 32'h22);
      check_output("copy_irq", 32'(irq), 32'd1);
      apply_stimulus(REG_CTRL, 32'h0);
      #1;
      check_output("irq_clear", 32'(irq), 32'd0);
      read_reg(REG_CTRL, v);
      check_output("irq_clear_status", v, 32'h02);

      // Fill of three halfwords: no reads at all.
      clear_logs();
      apply_stimulus(REG_FILL, 32'hA55A);
      apply_stimulus(REG_DST, 32'h0100);
      apply_stimulus(REG_LEN, 32'd3);
      apply_stimulus(REG_CTRL, 32'h3);
      wait_idle(2000);
      check_output("fill_ops", 32'(op_log.size()), 32'd3);
      check_output("fill_wr_count", 32'(wr_addr.size()), 32'd3);
      for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
         check_output($sformatf("fill_addr%0d", i), 32'(wr_addr[i]), 32'h100 + 32'(2 * i));
         check_output($sformatf("fill_data%0d", i), 32'(wr_data[i]), 32'hA55A);
      end
      read_reg(REG_CTRL, v);
      check_output("fill_status", v, 32'h12);

      // Fill across the top of the address space.
      clear_logs();
      apply_stimulus(REG_FILL, 32'h1234);
      apply_stimulus(REG_DST, 32'h3FFFFFC);
      apply_stimulus(REG_LEN, 32'd4);
      apply_stimulus(REG_CTRL, 32'h3);
      wait_idle(2000);
      check_output("wrap_wr_count", 32'(wr_addr.size()), 32'd4);
      if (wr_addr.size() == 4) begin
         check_output("wrap_addr0", 32'(wr_addr[0]), 32'h3FFFFFC);
         check_output("wrap_addr1", 32'(wr_addr[1]), 32'h3FFFFFE);
         check_output("wrap_addr2", 32'(wr_addr[2]), 32'h0000000);
         check_output("wrap_addr3", 32'(wr_addr[3]), 32'h0000002);
         check_output("wrap_data3", 32'(wr_data[3]), 32'h1234);
      end
      read_reg(REG_DST, v);
      check_output("wrap_dst_end", v, 32'h4);

      // Same copy with five wait cycles per access.
      clear_logs();
      wait_n = 5;
      apply_stimulus(REG_SRC, 32'h1000);
      apply_stimulus(REG_DST, 32'h3000);
      apply_stimulus(REG_LEN, 32'd20);
      apply_stimulus(REG_CTRL, 32'h1);
      wait_idle(3000);
      check_copy("wait", 26'h1000, 26'h3000, 20);
      check_output("wait_stable", 32'(stab_err), 32'd0);
      read_reg(REG_CTRL, v);
      check_output("wait_status", v, 32'h02);

      // Abort while the third write is stalled.
      clear_logs();
      apply_stimulus(REG_SRC, 32'h1000);
      apply_stimulus(REG_DST, 32'h2000);
      apply_stimulus(REG_LEN, 32'd20);
      apply_stimulus(REG_CTRL, 32'h1);
      n_wait = 0;
      while (!(wr_addr.size() == 2 && m_cs && m_wr && !m_nwait) && n_wait < 3000) begin
         @(negedge clk);
         #1;
         n_wait++;
      end
      check_output("abort_reach", 32'(n_wait < 3000), 32'd1);
      apply_stimulus(REG_CTRL, 32'h8);
      wait_idle(3000);
      check_output("abort_wr_count", 32'(wr_addr.size()), 32'd3);
      check_output("abort_stable", 32'(stab_err), 32'd0);
      read_reg(REG_CTRL, v);
      check_output("abort_status", v, 32'h04);
      read_reg(REG_LEN, v);
      check_output("abort_len", v, 32'd17);
      read_reg(REG_DST, v);
      check_output("abort_dst", v, 32'h2006);
      read_reg(REG_SRC, v);
      check_output("abort_src", v, 32'h1010);
      check_output("abort_irq", 32'(irq), 32'd0);

      // Zero-length start completes without any bus cycle.
      clear_logs();
      wait_n = 0;
      apply_stimulus(REG_LEN, 32'd0);
      apply_stimulus(REG_CTRL, 32'h5);
      @(negedge clk);
      check_output("len0_irq", 32'(irq), 32'd1);
      read_reg(REG_CTRL, v);
      check_output("len0_status", v, 32'h22);
      check_output("len0_no_cs", 32'(cs_seen), 32'd0);

      // Start together with abort must not begin a transfer.
      clear_logs();
      apply_stimulus(REG_LEN, 32'd5);
      apply_stimulus(REG_CTRL, 32'h9);
      repeat (3) @(negedge clk);
      read_reg(REG_CTRL, v);
      check_output("startabort_busy", 32'(v[STAT_BUSY]), 32'd0);
      check_output("startabort_no_cs", 32'(cs_seen), 32'd0);

      // Reset in the middle of a copy.
      apply_stimulus(REG_SRC, 32'h1000);
      apply_stimulus(REG_DST, 32'h2000);
      apply_stimulus(REG_LEN, 32'd20);
      apply_stimulus(REG_CTRL, 32'h5);
      repeat (10) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_output("midrst_strobes", 32'({m_cs, m_rd, m_wr}), 32'd0);
      check_output("midrst_addr", 32'(m_addr), 32'd0);
      check_output("midrst_wdata", 32'(m_wdata), 32'd0);
      check_output("midrst_irq", 32'(irq), 32'd0);
      read_reg(REG_SRC, v);
      check_output("midrst_src", v, 32'd0);
      read_reg(REG_CTRL, v);
      check_output("midrst_status", v, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
